// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift/rotate sequencer:
// operand widths, shift mode encodings and the controller state type.
package shift_sequencer_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_ROR = 2'b10;
  localparam logic [1:0] SH_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// One log-shifter stage: shifts the operand by 2^stage_i using the fill or wrap
// that the mode selects; the reserved mode passes the operand through unchanged.
module shift_stage
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] value_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       stage_i,
  output logic [WIDTH-1:0] value_o
);

  logic [4:0] amt;

  assign amt = 5'd1 << stage_i;

  always_comb begin
    value_o = value_i;
    case (mode_i)
      SH_SLL:  value_o = value_i << amt;
      SH_SRA:  value_o = $unsigned($signed(value_i) >>> amt);
      SH_ROR:  value_o = (value_i >> amt) | (value_i << (5'(WIDTH) - amt));
      default: value_o = value_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Two-port round-robin shift/rotate controller: accepts one request, runs four
// log-shifter stages on a shared datapath, then holds the tagged result until taken.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_mode,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_mode,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_id,
  output logic               rsp_err,
  output logic               busy
);

  state_e             state_q, state_d;
  logic               lastGrant_q, lastGrant_d;
  logic [1:0]         stage_q, stage_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         mode_q, mode_d;
  logic               id_q, id_d;
  logic               grant;
  logic               accept;
  logic [WIDTH-1:0]   stageOut;

  shift_stage u_stage (
    .value_i (work_q),
    .mode_i  (mode_q),
    .stage_i (stage_q),
    .value_o (stageOut)
  );

  // A lone requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    grant = ~lastGrant_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
    req0_ready = (state_q == IDLE) && req0_valid && !grant;
    req1_ready = (state_q == IDLE) && req1_valid && grant;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    stage_d     = stage_q;
    work_d      = work_q;
    shamt_d     = shamt_q;
    mode_d      = mode_q;
    id_d        = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d      = grant ? req1_data  : req0_data;
          shamt_d     = grant ? req1_shamt : req0_shamt;
          mode_d      = grant ? req1_mode  : req0_mode;
          id_d        = grant;
          lastGrant_d = grant;
          stage_d     = 2'd0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (shamt_q[stage_q]) begin
          work_d = stageOut;
        end
        stage_d = stage_q + 2'd1;
        if (stage_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      stage_q     <= 2'd0;
      work_q      <= '0;
      shamt_q     <= '0;
      mode_q      <= SH_SLL;
      id_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      stage_q     <= stage_d;
      work_q      <= work_d;
      shamt_q     <= shamt_d;
      mode_q      <= mode_d;
      id_q        <= id_d;
    end
  end

  // Response fields are masked outside DONE so nothing stale leaks out mid-shift.
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_valid ? work_q : '0;
  assign rsp_id    = rsp_valid && id_q;
  assign rsp_err   = rsp_valid && (mode_q == SH_RSV);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: each scenario task drives hand-computed
// vectors and compares the response fields inline.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_mode, req1_mode;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0] rsp_data;

  int compared   = 0;
  int mismatched = 0;

  shift_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Offers one request and returns 1ns after the accepting edge.
  task automatic sendReq(input bit port, input logic [15:0] data,
                         input logic [3:0] shamt, input logic [1:0] mode);
    bit accepted = 1'b0;
    bit rdy;
    if (port) begin
      req1_valid = 1'b1; req1_data = data; req1_shamt = shamt; req1_mode = mode;
    end else begin
      req0_valid = 1'b1; req0_data = data; req0_shamt = shamt; req0_mode = mode;
    end
    for (int i = 0; i < 30 && !accepted; i++) begin
      @(negedge clk);
      rdy = port ? req1_ready : req0_ready;
      @(posedge clk);
      accepted = rdy;
    end
    #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!accepted) begin
      compared++; mismatched++;
      $display("[TB] FAIL accept_timeout: port %0d not accepted, required accept within 30 cycles", port);
    end
  endtask

  task automatic waitRsp(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
  endtask

  task automatic finishRsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = 16'h0; req1_data = 16'h0; req0_shamt = 4'h0; req1_shamt = 4'h0;
    req0_mode = 2'b00; req1_mode = 2'b00;
    #2;
    compared++;
    if ({busy, rsp_valid, rsp_data, rsp_id, rsp_err} !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got busy=%b valid=%b data=%h id=%b err=%b, required all 0",
               busy, rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    compared++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL reset_ready_single: got %b, required 10", {req0_ready, req1_ready});
    end
    req1_valid = 1'b1;
    #1;
    compared++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL reset_ready_tie: got %b, required 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ror();
    int lat;
    sendReq(1'b0, 16'h1234, 4'd4, 2'b10);
    waitRsp(lat);
    compared++;
    if (lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL ror_latency: got %0d, required 4", lat);
    end
    compared++;
    if ({rsp_data, rsp_id, rsp_err} !== {16'h4123, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL ror_result: got data=%h id=%b err=%b, required data=4123 id=0 err=0",
               rsp_data, rsp_id, rsp_err);
    end
    finishRsp();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ror_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_edge_amounts();
    logic [15:0] vData [3] = '{16'h8000, 16'h0001, 16'hABCD};
    logic [3:0]  vShamt[3] = '{4'd15, 4'd15, 4'd0};
    logic [1:0]  vMode [3] = '{2'b01, 2'b00, 2'b10};
    logic [15:0] vExp  [3] = '{16'hFFFF, 16'h8000, 16'hABCD};
    int lat;
    for (int i = 0; i < 3; i++) begin
      sendReq(1'b0, vData[i], vShamt[i], vMode[i]);
      waitRsp(lat);
      compared++;
      if (lat !== 4) begin
        mismatched++;
        $display("[TB] FAIL edge_latency[%0d]: got %0d, required 4", i, lat);
      end
      compared++;
      if (rsp_data !== vExp[i]) begin
        mismatched++;
        $display("[TB] FAIL edge_data[%0d]: got %h, required %h", i, rsp_data, vExp[i]);
      end
      finishRsp();
    end
  endtask

  task automatic test_reserved();
    int lat;
    sendReq(1'b0, 16'h5A5A, 4'd3, 2'b11);
    waitRsp(lat);
    compared++;
    if ({rsp_data, rsp_err, lat} !== {16'h5A5A, 1'b1, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL reserved_result: got data=%h err=%b lat=%0d, required data=5a5a err=1 lat=4",
               rsp_data, rsp_err, lat);
    end
    finishRsp();
    sendReq(1'b1, 16'h0003, 4'd1, 2'b00);
    waitRsp(lat);
    compared++;
    if ({rsp_data, rsp_id, rsp_err} !== {16'h0006, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reserved_next: got data=%h id=%b err=%b, required data=0006 id=1 err=0",
               rsp_data, rsp_id, rsp_err);
    end
    finishRsp();
  endtask

  task automatic test_tie();
    int          expPort[3] = '{0, 1, 0};
    logic [15:0] expData[3] = '{16'h0011, 16'h0022, 16'h0033};
    int granted, g, lat;
    doReset();
    req0_data = 16'h0011; req0_shamt = 4'd0; req0_mode = 2'b00;
    req1_data = 16'h0022; req1_shamt = 4'd0; req1_mode = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      granted = 2;
      for (int i = 0; i < 30 && granted == 2; i++) begin
        @(negedge clk);
        g = req0_ready ? 0 : (req1_ready ? 1 : 2);
        @(posedge clk);
        granted = g;
      end
      #1;
      if (t == 0) req0_data = 16'h0033;
      if (t == 1) req1_data = 16'h0044;
      if (t == 2) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      compared++;
      if (granted !== expPort[t]) begin
        mismatched++;
        $display("[TB] FAIL tie_grant[%0d]: got port %0d, required port %0d", t, granted, expPort[t]);
      end
      waitRsp(lat);
      compared++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, expPort[t][0], expData[t]}) begin
        mismatched++;
        $display("[TB] FAIL tie_rsp[%0d]: got valid=%b id=%b data=%h, required valid=1 id=%0d data=%h",
                 t, rsp_valid, rsp_id, rsp_data, expPort[t], expData[t]);
      end
      finishRsp();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    sendReq(1'b0, 16'h0003, 4'd2, 2'b00);
    waitRsp(lat);
    req0_valid = 1'b1; req0_data = 16'h0101;
    req1_valid = 1'b1; req1_data = 16'h0202;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({rsp_valid, rsp_data, req0_ready, req1_ready} !== {1'b1, 16'h000C, 2'b00}) begin
        mismatched++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b%b, required valid=1 data=000c ready=00",
                 i, rsp_valid, rsp_data, req0_ready, req1_ready);
      end
    end
    req0_valid = 1'b0;
    finishRsp();
    compared++;
    if ({busy, rsp_valid, req1_ready} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL bp_release: got busy=%b valid=%b req1_ready=%b, required 0 0 1",
               busy, rsp_valid, req1_ready);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    sendReq(1'b0, 16'hFFFF, 4'hF, 2'b01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_busy: got %b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({busy, rsp_valid, rsp_data, rsp_id, rsp_err, req0_ready, req1_ready} !== 22'h0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: got busy=%b valid=%b data=%h id=%b err=%b ready=%b%b, required all 0",
               busy, rsp_valid, rsp_data, rsp_id, rsp_err, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sendReq(1'b1, 16'h00F0, 4'd4, 2'b00);
    waitRsp(lat);
    compared++;
    if ({rsp_data, rsp_id, rsp_err, lat} !== {16'h0F00, 1'b1, 1'b0, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL mid_after: got data=%h id=%b err=%b lat=%0d, required data=0f00 id=1 err=0 lat=4",
               rsp_data, rsp_id, rsp_err, lat);
    end
    finishRsp();
  endtask

  initial begin
    test_reset();
    test_ror();
    test_edge_amounts();
    test_reserved();
    test_tie();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
